// File: rtl/boot_ctrl_pkg.sv
// boot_ctrl_pkg: state encoding, word width and reset-PC default shared by inst_boot_ctrl and boot_checksum.
package boot_ctrl_pkg;
    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] PC_INITIAL_DEF = 32'hbfc00000;
    typedef enum logic [2:0] {IDLE, LOAD, SETTLE, RUN, ERR} state_t;
    function automatic logic [WORD_W-1:0] word_addr(input logic [WORD_W-1:0] base, input logic [WORD_W-1:0] idx);
        return base + (idx << 2);
    endfunction
endpackage

// File: rtl/boot_checksum.sv
// boot_checksum: wrap-around 32-bit sum of program words with clear/add, compared against an expected word.
module boot_checksum
    import boot_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              add,
    input  logic [WORD_W-1:0] data,
    input  logic [WORD_W-1:0] expected,
    output logic              match
);
    logic [WORD_W-1:0] sum;
    always_ff @(posedge clk) begin
        if (!reset || clear) sum <= '0;
        else if (add) sum <= sum + data;
    end
    assign match = sum == expected;
endmodule

// File: rtl/inst_boot_ctrl.sv
// inst_boot_ctrl: streams a host program into instruction RAM at the reset PC, settles, then releases the CPU.
// Define BOOT_CHECKSUM_EN to require a trailing wrap-around sum word after the in_last word.
module inst_boot_ctrl
    import boot_ctrl_pkg::*;
#(
    parameter logic [WORD_W-1:0] PC_INITIAL    = PC_INITIAL_DEF,
    parameter int                MAX_WORDS     = 64,
    parameter int                SETTLE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              inst_ram_write_enable,
    output logic [WORD_W-1:0] inst_ram_write_data,
    output logic [WORD_W-1:0] inst_ram_write_address,
    output logic              debug,
    output logic              cpu_reset,
    output logic              load_error
);
    localparam int CW = $clog2(MAX_WORDS) + 1;
    localparam int SW = $clog2(SETTLE_CYCLES) + 1;
    state_t        state;
    logic [CW-1:0] cnt;
    logic [SW-1:0] settle;
    logic          ck_phase;
    logic          ck_match;
    logic          accept;
    logic          load_go;
    assign accept  = in_valid & in_ready;
    assign load_go = load_start & (state == IDLE || state == RUN || state == ERR);
`ifdef BOOT_CHECKSUM_EN
    localparam bit CK_EN = 1'b1;
    boot_checksum u_checksum (
        .clk      (clk),
        .reset    (reset),
        .clear    (load_go),
        .add      (accept & ~ck_phase),
        .data     (in_data),
        .expected (in_data),
        .match    (ck_match)
    );
`else
    localparam bit CK_EN = 1'b0;
    assign ck_match = 1'b1;
`endif
    always_ff @(posedge clk) begin
        if (!reset) begin
            state                  <= IDLE;
            in_ready               <= 1'b0;
            inst_ram_write_enable  <= 1'b0;
            inst_ram_write_data    <= '0;
            inst_ram_write_address <= PC_INITIAL;
            debug                  <= 1'b1;
            cpu_reset              <= 1'b0;
            load_error             <= 1'b0;
            cnt                    <= '0;
            settle                 <= '0;
            ck_phase               <= 1'b0;
        end else begin
            inst_ram_write_enable <= 1'b0;
            if (load_go) begin
                state                  <= LOAD;
                in_ready               <= 1'b1;
                inst_ram_write_address <= PC_INITIAL;
                cnt                    <= '0;
                debug                  <= 1'b1;
                cpu_reset              <= 1'b0;
                load_error             <= 1'b0;
                ck_phase               <= 1'b0;
            end else if (state == LOAD && accept) begin
                if (ck_phase) begin
                    in_ready   <= 1'b0;
                    state      <= ck_match ? SETTLE : ERR;
                    load_error <= ~ck_match;
                    settle     <= SW'(SETTLE_CYCLES - 1);
                end else begin
                    inst_ram_write_enable  <= 1'b1;
                    inst_ram_write_data    <= in_data;
                    inst_ram_write_address <= word_addr(PC_INITIAL, 32'(cnt));
                    cnt                    <= cnt + 1'b1;
                    if (in_last && CK_EN) begin
                        ck_phase <= 1'b1;
                    end else if (in_last) begin
                        state    <= SETTLE;
                        in_ready <= 1'b0;
                        settle   <= SW'(SETTLE_CYCLES - 1);
                    end else if (cnt == CW'(MAX_WORDS - 1)) begin
                        state      <= ERR;
                        in_ready   <= 1'b0;
                        load_error <= 1'b1;
                    end
                end
            // the settle interval starts counting once the last RAM write is out
            end else if (state == SETTLE && !inst_ram_write_enable) begin
                if (settle == '0) begin
                    state     <= RUN;
                    debug     <= 1'b0;
                    cpu_reset <= 1'b1;
                end else begin
                    settle <= settle - 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_inst_boot_ctrl.sv
// tb_inst_boot_ctrl: scoreboard bench for inst_boot_ctrl with MAX_WORDS=4, SETTLE_CYCLES=4.
module tb_inst_boot_ctrl;
    localparam logic [31:0] PC = 32'hbfc00000;
    localparam int SETTLE = 4;
`ifdef BOOT_CHECKSUM_EN
    localparam int REL = SETTLE;
`else
    localparam int REL = SETTLE + 1;
`endif
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        load_start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready;
    logic        inst_ram_write_enable;
    logic [31:0] inst_ram_write_data;
    logic [31:0] inst_ram_write_address;
    logic        debug;
    logic        cpu_reset;
    logic        load_error;
    int          checks = 0;
    int          errors = 0;
    int          idx = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    inst_boot_ctrl #(.PC_INITIAL(PC), .MAX_WORDS(4), .SETTLE_CYCLES(SETTLE)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .load_start             (load_start),
        .in_valid               (in_valid),
        .in_data                (in_data),
        .in_last                (in_last),
        .in_ready               (in_ready),
        .inst_ram_write_enable  (inst_ram_write_enable),
        .inst_ram_write_data    (inst_ram_write_data),
        .inst_ram_write_address (inst_ram_write_address),
        .debug                  (debug),
        .cpu_reset              (cpu_reset),
        .load_error             (load_error)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // write-port monitor: every strobe must match the oldest outstanding expected write
    always @(negedge clk) begin
        if (inst_ram_write_enable) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %h data %h expected no write", inst_ram_write_address, inst_ram_write_data);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                chk("wr_addr", inst_ram_write_address, e[63:32]);
                chk("wr_data", inst_ram_write_data, e[31:0]);
            end
        end
    end

    task automatic pulse_load();
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        idx = 0;
    endtask

    task automatic send(input logic [31:0] d, input logic l, input int gap, input bit wr);
        int n = 0;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_wait", 32'(in_ready), 32'd1);
        if (wr) begin
            exp_q.push_back({PC + 32'(idx) * 32'd4, d});
            idx++;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic prog(input int gap);
        send(32'h200FFAF4, 1'b0, gap, 1'b1);
        send(32'h3C180123, 1'b0, gap, 1'b1);
        send(32'h01F87820, 1'b1, gap, 1'b1);
`ifdef BOOT_CHECKSUM_EN
        send(32'h5E207437, 1'b0, gap, 1'b0);
`endif
    endtask

    task automatic wait_run();
        int n = 0;
        while (debug && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("run_debug", 32'(debug), 32'd0);
        chk("run_cpu_reset", 32'(cpu_reset), 32'd1);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_debug"}, 32'(debug), 32'd1);
        chk({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_we"}, 32'(inst_ram_write_enable), 32'd0);
        chk({tag, "_addr"}, inst_ram_write_address, PC);
        chk({tag, "_load_error"}, 32'(load_error), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        chk_reset_state("reset");
        reset = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", 32'(in_ready), 32'd0);
        chk("idle_cpu_reset", 32'(cpu_reset), 32'd0);
        // back-to-back stream and release timing
        pulse_load();
        chk("load_in_ready", 32'(in_ready), 32'd1);
        prog(0);
        repeat (REL - 1) @(negedge clk);
        chk("pre_release_cpu_reset", 32'(cpu_reset), 32'd0);
        chk("pre_release_debug", 32'(debug), 32'd1);
        @(negedge clk);
        chk("release_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("release_debug", 32'(debug), 32'd0);
        // reload from RUN re-holds the CPU on the load_start edge; gapped stream
        pulse_load();
        chk("rehold_debug", 32'(debug), 32'd1);
        chk("rehold_cpu_reset", 32'(cpu_reset), 32'd0);
        chk("rehold_in_ready", 32'(in_ready), 32'd1);
        prog(1);
        wait_run();
        // overflow: MAX_WORDS words with no in_last
        pulse_load();
        send(32'h11111111, 1'b0, 0, 1'b1);
        send(32'h22222222, 1'b0, 0, 1'b1);
        send(32'h33333333, 1'b0, 0, 1'b1);
        send(32'h44444444, 1'b0, 0, 1'b1);
        chk("ovf_load_error", 32'(load_error), 32'd1);
        chk("ovf_debug", 32'(debug), 32'd1);
        chk("ovf_cpu_reset", 32'(cpu_reset), 32'd0);
        chk("ovf_in_ready", 32'(in_ready), 32'd0);
        repeat (2) @(negedge clk);
        chk("ovf_sticky", 32'(load_error), 32'd1);
        pulse_load();
        chk("clr_load_error", 32'(load_error), 32'd0);
        chk("clr_in_ready", 32'(in_ready), 32'd1);
        // single word then reset mid-load
        send(32'h00000000, 1'b0, 0, 1'b1);
        reset = 1'b0;
        @(negedge clk);
        chk_reset_state("midload");
        reset = 1'b1;
        @(negedge clk);
`ifdef BOOT_CHECKSUM_EN
        pulse_load();
        send(32'd1, 1'b0, 0, 1'b1);
        send(32'd2, 1'b1, 0, 1'b1);
        send(32'd3, 1'b0, 0, 1'b0);
        wait_run();
        pulse_load();
        send(32'd1, 1'b0, 0, 1'b1);
        send(32'd2, 1'b1, 0, 1'b1);
        send(32'd4, 1'b0, 0, 1'b0);
        repeat (2) @(negedge clk);
        chk("ck_bad_load_error", 32'(load_error), 32'd1);
        chk("ck_bad_debug", 32'(debug), 32'd1);
        chk("ck_bad_cpu_reset", 32'(cpu_reset), 32'd0);
`endif
        repeat (3) @(negedge clk);
        chk("writes_outstanding", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/inst_boot_ctrl.md
# inst_boot_ctrl

Boot sequencer between a host word stream and the CPU's instruction-RAM write port. Holds the CPU in debug/reset, writes an incoming program word-by-word into instruction RAM starting at the reset PC, waits a settle interval, then releases the CPU to run. It replaces hand-sequenced instruction loading in benches and board tops.

## Interface
- PC_INITIAL, 32'hbfc00000, first instruction-RAM write address and CPU reset vector
- MAX_WORDS, 64, maximum program length in words (≥2)
- SETTLE_CYCLES, 4, cycles between the last RAM write and CPU release (≥1)
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low; clears every register on the next edge
- load_start  in  1  single-cycle pulse requesting a (re)load
- in_valid  in  1  host word valid
- in_data  in  32  host instruction word
- in_last  in  1  marks final program word; qualified by in_valid
- in_ready  out  1  block accepts a word this cycle
- inst_ram_write_enable  out  1  registered RAM write strobe
- inst_ram_write_data  out  32  registered RAM write data
- inst_ram_write_address  out  32  registered RAM write address
- debug  out  1  1 = CPU in debug/load mode
- cpu_reset  out  1  CPU reset, active-low: 0 holds CPU, 1 runs
- load_error  out  1  sticky error flag, cleared by load_start or reset

## Operation
- States: IDLE, LOAD, SETTLE, RUN, ERR.
- Reset values: state IDLE, in_ready 0, inst_ram_write_enable 0, write data 0, write address PC_INITIAL, debug 1, cpu_reset 0, load_error 0, word counter 0.
- IDLE: CPU held (debug 1, cpu_reset 0). load_start → LOAD, address ← PC_INITIAL, counter ← 0.
- LOAD: in_ready 1. Accept = in_valid & in_ready. On accept: write enable 1, data ← in_data, address ← PC_INITIAL + 4·counter, counter +1. in_last on accept → SETTLE. Accept of word MAX_WORDS without in_last → word written, then ERR.
- SETTLE: in_ready 0; down-counter loaded with SETTLE_CYCLES-1; at 0 → RUN.
- RUN: debug 0, cpu_reset 1, in_ready 0. load_start → LOAD (CPU re-held in the same edge: debug 1, cpu_reset 0).
- ERR: load_error 1, CPU held, in_ready 0. load_start → LOAD, load_error ← 0.
- load_start ignored in LOAD and SETTLE.
- Address arithmetic: 32-bit, wraps modulo 2^32; counter width clog2(MAX_WORDS)+1.
- reset low mid-load: next edge returns to reset values; partial RAM contents are not erased.

## Timing
- Word accepted at edge N appears on RAM write port during cycle N+1 (1-cycle latency); write enable high exactly one cycle per accepted word.
- Back-to-back accepts sustain one word per cycle.
- Last word accepted at edge N: RAM write cycle N+1, CPU released (cpu_reset 1, debug 0) at edge N+SETTLE_CYCLES+1.
- load_start at edge N in IDLE/RUN/ERR: in_ready 1 from cycle N+1.

## Configuration
- BOOT_CHECKSUM_EN defined: after the in_last word, LOAD stays open for one more accepted word, taken as the expected 32-bit wrap-around sum of all program words; this word is not written to RAM. Match → SETTLE; mismatch → ERR.
- Undefined: no checksum word; in_last transitions directly to SETTLE.

## Structure
- Package boot_ctrl_pkg: state enum (IDLE, LOAD, SETTLE, RUN, ERR), PC_INITIAL default, word-width constant 32.
- Sub-module boot_checksum: 32-bit accumulator with clear/add/compare, instantiated only under BOOT_CHECKSUM_EN.

## Test plan
- Reset low 2 cycles, then high → debug 1, cpu_reset 0, in_ready 0, address 32'hbfc00000, no writes.
- load_start, stream 3 words 32'h200FFAF4, 32'h3C180123, 32'h01F87820 (last on 3rd) back-to-back → writes at bfc00000/bfc00004/bfc00008, cpu_reset 1 exactly SETTLE_CYCLES+1 edges after 3rd accept.
- Same stream with in_valid gapped every other cycle → identical writes, no duplicates, no extra strobes.
- MAX_WORDS=4, send 4 words without in_last → 4 writes, load_error 1, CPU held; load_start clears load_error, in_ready 1 next cycle.
- In RUN, load_start → debug 1, cpu_reset 0 same edge; reload 1 word 32'h00000000 writes bfc00000; reset low mid-load → reset values next edge.
- BOOT_CHECKSUM_EN: words 1, 2 (last), checksum 3 → RUN, 2 writes only; checksum 4 → ERR, load_error 1.
